// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single handshaked memory.
// One access at a time, round-robin on ties, with a per-access response timeout.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_done,
    output logic        if_err,
    output logic [15:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_done,
    output logic        d_err,
    output logic [15:0] d_rdata,
    output logic [15:0] addr,
    output logic        read_mem_req,
    input  logic        read_mem_valid,
    input  logic        read_mem_finish,
    input  logic [15:0] in_mem_data,
    output logic        write_mem_req,
    input  logic        write_mem_valid,
    input  logic        write_mem_finish,
    output logic [15:0] out_mem_data
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_REQ  = 3'd1;
    localparam logic [2:0] RD_WAIT = 3'd2;
    localparam logic [2:0] WR_REQ  = 3'd3;
    localparam logic [2:0] WR_WAIT = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    logic [2:0]  state;
    logic        gnt_d;     // current access belongs to the data port
    logic        gnt_we;    // current access is a store
    logic        last_d;    // last finished/aborted access was the data port
    logic [15:0] rbuf;
    logic [15:0] wait_cnt;
    logic        pick_d;
    logic        timed_out;

    always_comb begin
        pick_d    = d_req && (!if_req || !last_d);
        // The current cycle is the last one allowed before the access is abandoned.
        timed_out = ({1'b0, wait_cnt} + 17'd1) >= 17'(TIMEOUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            gnt_d         <= 1'b0;
            gnt_we        <= 1'b0;
            last_d        <= 1'b1;
            rbuf          <= 16'h0000;
            wait_cnt      <= 16'h0000;
            addr          <= 16'h0000;
            out_mem_data  <= 16'h0000;
            read_mem_req  <= 1'b0;
            write_mem_req <= 1'b0;
            if_done       <= 1'b0;
            if_err        <= 1'b0;
            if_rdata      <= 16'h0000;
            d_done        <= 1'b0;
            d_err         <= 1'b0;
            d_rdata       <= 16'h0000;
        end else begin
            if_done <= 1'b0;
            if_err  <= 1'b0;
            d_done  <= 1'b0;
            d_err   <= 1'b0;
            if (state != IDLE && state != DONE && wait_cnt != 16'hFFFF)
                wait_cnt <= wait_cnt + 16'd1;

            case (state)
                IDLE: begin
                    if (if_req || d_req) begin
                        gnt_d    <= pick_d;
                        gnt_we   <= pick_d && d_we;
                        wait_cnt <= 16'h0000;
                        if (pick_d) begin
                            addr <= d_addr;
                            if (d_we) begin
                                out_mem_data  <= d_wdata;
                                write_mem_req <= 1'b1;
                                state         <= WR_REQ;
                            end else begin
                                read_mem_req <= 1'b1;
                                state        <= RD_REQ;
                            end
                        end else begin
                            addr         <= if_addr;
                            read_mem_req <= 1'b1;
                            state        <= RD_REQ;
                        end
                    end
                end
                RD_REQ: begin
                    if (read_mem_valid && read_mem_finish) begin
                        rbuf         <= in_mem_data;
                        read_mem_req <= 1'b0;
                        state        <= DONE;
                    end else if (timed_out) begin
                        read_mem_req <= 1'b0;
                        if (gnt_d) d_err <= 1'b1; else if_err <= 1'b1;
                        last_d <= gnt_d;
                        state  <= IDLE;
                    end else if (read_mem_valid) begin
                        rbuf         <= in_mem_data;
                        read_mem_req <= 1'b0;
                        state        <= RD_WAIT;
                    end
                end
                RD_WAIT, WR_WAIT: begin
                    if ((state == RD_WAIT) ? read_mem_finish : write_mem_finish) begin
                        state <= DONE;
                    end else if (timed_out) begin
                        if (gnt_d) d_err <= 1'b1; else if_err <= 1'b1;
                        last_d <= gnt_d;
                        state  <= IDLE;
                    end
                end
                WR_REQ: begin
                    if (write_mem_valid && write_mem_finish) begin
                        write_mem_req <= 1'b0;
                        state         <= DONE;
                    end else if (timed_out) begin
                        write_mem_req <= 1'b0;
                        d_err         <= 1'b1;
                        last_d        <= gnt_d;
                        state         <= IDLE;
                    end else if (write_mem_valid) begin
                        write_mem_req <= 1'b0;
                        state         <= WR_WAIT;
                    end
                end
                DONE: begin
                    // Read data only becomes visible on the port together with its done pulse.
                    if (gnt_d) begin
                        d_done <= 1'b1;
                        if (!gnt_we) d_rdata <= rbuf;
                    end else begin
                        if_done  <= 1'b1;
                        if_rdata <= rbuf;
                    end
                    last_d <= gnt_d;
                    state  <= IDLE;
                end
                default: begin
                    read_mem_req  <= 1'b0;
                    write_mem_req <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized transaction-level check of mem_arbiter: the bench plays both requesters and
// the memory, predicting grant order, response cycle, pulses and data from the access rules.
module tb_mem_arbiter;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_req, d_we;
    logic [15:0] if_addr, d_addr, d_wdata;
    logic        if_done, if_err, d_done, d_err;
    logic [15:0] if_rdata, d_rdata;
    logic [15:0] addr, in_mem_data, out_mem_data;
    logic        read_mem_req, read_mem_valid, read_mem_finish;
    logic        write_mem_req, write_mem_valid, write_mem_finish;

    mem_arbiter #(.TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_err(if_err), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_err(d_err), .d_rdata(d_rdata),
        .addr(addr), .read_mem_req(read_mem_req), .read_mem_valid(read_mem_valid),
        .read_mem_finish(read_mem_finish), .in_mem_data(in_mem_data),
        .write_mem_req(write_mem_req), .write_mem_valid(write_mem_valid),
        .write_mem_finish(write_mem_finish), .out_mem_data(out_mem_data)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // reference state: last port data, last store data, who was served last
    logic [15:0] m_if_rdata, m_d_rdata, m_out;
    bit          last_d;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic mem_idle();
        read_mem_valid = 1'b0; read_mem_finish = 1'b0;
        write_mem_valid = 1'b0; write_mem_finish = 1'b0;
    endtask

    // One access from IDLE. Memory asserts valid dv cycles into the request and finish df
    // cycles after that; requester inputs are scrambled once the grant has been taken.
    task automatic access(input bit fr, input bit dr, input bit we,
                          input logic [15:0] fa, input logic [15:0] da, input logic [15:0] wd,
                          input int dv, input int df, input logic [15:0] rd);
        bit gd, wr, is_err;
        logic [15:0] ea;
        int f, lim, kexp, kobs;
        gd     = (fr && dr) ? !last_d : dr;
        wr     = gd && we;
        ea     = gd ? da : fa;
        f      = dv + df;
        lim    = (dv < T - 1) ? dv : T - 1;
        is_err = f > T - 1;
        kexp   = is_err ? T : f + 2;
        @(negedge clk);
        if_req = fr; if_addr = fa; d_req = dr; d_we = we; d_addr = da; d_wdata = wd;
        kobs = -1;
        for (int k = 0; k < T + 12 && kobs < 0; k++) begin
            @(negedge clk);
            if_req = 1'b0; d_req = 1'b0;
            if_addr = 16'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom); d_we = 1'($urandom);
            if (if_done || if_err || d_done || d_err) begin
                kobs = k;
            end else begin
                check("rd_req", 32'(read_mem_req), 32'(!wr && k <= lim));
                check("wr_req", 32'(write_mem_req), 32'(wr && k <= lim));
                check("addr", 32'(addr), 32'(ea));
                check("out_data", 32'(out_mem_data), 32'(wr ? wd : m_out));
                if (wr) begin
                    write_mem_valid = (k == dv); write_mem_finish = (k == f);
                    read_mem_valid = 1'($urandom); read_mem_finish = 1'($urandom);
                end else begin
                    read_mem_valid = (k == dv); read_mem_finish = (k == f);
                    write_mem_valid = 1'($urandom); write_mem_finish = 1'($urandom);
                end
                in_mem_data = (k == dv) ? rd : 16'($urandom);
            end
        end
        check("pulse_cycle", 32'(kobs), 32'(kexp));
        check("if_done", 32'(if_done), 32'(!is_err && !gd));
        check("if_err", 32'(if_err), 32'(is_err && !gd));
        check("d_done", 32'(d_done), 32'(!is_err && gd));
        check("d_err", 32'(d_err), 32'(is_err && gd));
        if (!is_err && !wr) begin
            if (gd) m_d_rdata = rd; else m_if_rdata = rd;
        end
        if (wr) m_out = wd;
        last_d = gd;
        check("if_rdata", 32'(if_rdata), 32'(m_if_rdata));
        check("d_rdata", 32'(d_rdata), 32'(m_d_rdata));
        mem_idle();
        @(negedge clk);
        check("pulse_width", 32'({if_done, if_err, d_done, d_err}), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, 32'({if_done, if_err, d_done, d_err, read_mem_req, write_mem_req}), 32'd0);
        check({tag, "_addr"}, 32'(addr), 32'd0);
        check({tag, "_out"}, 32'(out_mem_data), 32'd0);
        check({tag, "_if_rdata"}, 32'(if_rdata), 32'd0);
        check({tag, "_d_rdata"}, 32'(d_rdata), 32'd0);
    endtask

    initial begin
        int nf, nd, idx;
        logic [3:0] seq;
        logic [15:0] vdat;
        rst = 1'b1;
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = 16'h0; d_addr = 16'h0; d_wdata = 16'h0; in_mem_data = 16'h0;
        mem_idle();
        m_if_rdata = 16'h0; m_d_rdata = 16'h0; m_out = 16'h0; last_d = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // both ports held high: fetch, data, fetch, data with zero-wait memory
        @(negedge clk);
        if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; if_addr = 16'h0200; d_addr = 16'h0300;
        nf = 0; nd = 0; idx = 0; seq = 4'h0; vdat = 16'h0;
        for (int c = 0; c < 40 && idx < 4; c++) begin
            @(negedge clk);
            if (if_done) begin
                check("b2b_if_rdata", 32'(if_rdata), 32'(vdat));
                m_if_rdata = vdat; seq[idx] = 1'b0; idx++; nf++;
                if (nf == 2) if_req = 1'b0;
            end
            if (d_done) begin
                check("b2b_d_rdata", 32'(d_rdata), 32'(vdat));
                m_d_rdata = vdat; seq[idx] = 1'b1; idx++; nd++;
                if (nd == 2) d_req = 1'b0;
            end
            check("b2b_excl", 32'(read_mem_req & write_mem_req), 32'd0);
            read_mem_valid = read_mem_req; read_mem_finish = read_mem_req;
            if (read_mem_req) begin
                vdat = 16'($urandom);
                in_mem_data = vdat;
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        mem_idle();
        repeat (4) begin
            @(negedge clk);
            check("b2b_quiet", 32'({if_done, d_done, read_mem_req, write_mem_req}), 32'd0);
        end
        check("b2b_order", 32'(seq), 32'(4'b1010));
        check("b2b_nf", 32'(nf), 32'd2);
        check("b2b_nd", 32'(nd), 32'd2);
        last_d = 1'b1;

        // directed accesses
        access(1'b1, 1'b0, 1'b0, 16'h0040, 16'h0, 16'h0, 2, 0, 16'h1234);
        access(1'b0, 1'b1, 1'b1, 16'h0, 16'h8000, 16'hBEEF, 2, 1, 16'h0);
        access(1'b0, 1'b1, 1'b0, 16'h0, 16'h0444, 16'h0, 20, 0, 16'hDEAD);
        access(1'b1, 1'b0, 1'b0, 16'h0050, 16'h0, 16'h0, 0, 0, 16'hCAFE);
        access(1'b0, 1'b1, 1'b0, 16'h0, 16'h0123, 16'h0, 1, 7, 16'h7777);
        access(1'b1, 1'b1, 1'b0, 16'h0060, 16'h0070, 16'h0, 0, 7, 16'h4242);

        // reset in RD_WAIT
        @(negedge clk);
        if_req = 1'b1; if_addr = 16'h0100;
        @(negedge clk);
        if_req = 1'b0; read_mem_valid = 1'b1; in_mem_data = 16'h5555;
        @(negedge clk);
        read_mem_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("midrst");
        read_mem_finish = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("midrst_quiet", 32'({if_done, if_err, d_done, d_err, read_mem_req}), 32'd0);
        end
        mem_idle();
        m_if_rdata = 16'h0; m_d_rdata = 16'h0; m_out = 16'h0; last_d = 1'b1;
        access(1'b1, 1'b0, 1'b0, 16'h0900, 16'h0, 16'h0, 1, 1, 16'h9A9A);

        // randomized accesses
        for (int i = 0; i < 60; i++) begin
            bit fr, dr;
            int sel, dv, df;
            sel = int'($urandom_range(2, 0));
            fr  = (sel != 1);
            dr  = (sel != 0);
            dv  = ($urandom_range(9, 0) == 0) ? 20 : int'($urandom_range(4, 0));
            df  = int'($urandom_range(4, 0));
            access(fr, dr, 1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                   dv, df, 16'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the maximum cycles spent waiting for a memory response before the access is aborted.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on posedge clk.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports if_req  input  1, and if_addr  input  16: the instruction-fetch read request and its address.
REQ-005 SHALL have ports if_done  output  1, if_err  output  1, and if_rdata  output  16: the fetch completion pulse, the timeout pulse and the fetched word.
REQ-006 SHALL have ports d_req  input  1, d_we  input  1, d_addr  input  16, and d_wdata  input  16: the data request, with d_we 1=store and 0=load.
REQ-007 SHALL have ports d_done  output  1, d_err  output  1, and d_rdata  output  16: the data completion pulse, the timeout pulse and the load word.
REQ-008 SHALL have memory-side ports addr  output  16, read_mem_req  output  1, read_mem_valid  input  1, read_mem_finish  input  1, and in_mem_data  input  16.
REQ-009 SHALL have memory-side ports write_mem_req  output  1, write_mem_valid  input  1, write_mem_finish  input  1, and out_mem_data  output  16.

Function
REQ-010 SHALL implement the FSM states IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT and DONE, with all outputs registered.
REQ-011 SHALL, in IDLE, sample the requests and grant one requester per access; a store takes the WR_REQ path, and a fetch or load takes the RD_REQ path.
REQ-012 SHALL use round-robin arbitration: when if_req and d_req are both high, it grants the requester not served by the last completed or aborted access; after reset the fetch port wins the first tie.
REQ-013 SHALL, on grant, latch the address (and d_wdata for a store) into internal registers; requester inputs are ignored until that requester's done or err pulse.
REQ-014 SHALL, in RD_REQ, drive addr and hold read_mem_req=1; on read_mem_valid=1 it captures in_mem_data, drops read_mem_req the next cycle and enters RD_WAIT.
REQ-015 SHALL, in RD_WAIT, wait for read_mem_finish=1 and then enter DONE; if valid and finish arrive in the same cycle, it goes directly from RD_REQ to DONE.
REQ-016 SHALL, in WR_REQ, drive addr and out_mem_data and hold write_mem_req=1 until write_mem_valid=1, then enter WR_WAIT; it enters DONE on write_mem_finish=1, with the same-cycle rule of REQ-015.
REQ-017 SHALL, in DONE, pulse the granted requester's done for exactly one cycle, with if_rdata or d_rdata valid in that cycle and held until the next completion on that port, then return to IDLE.
REQ-018 SHALL give a total latency of at least 3 cycles from request high in IDLE to the done pulse, with zero-wait memory (valid and finish in the first req cycle).
REQ-019 SHALL keep a 16-bit wait counter that clears on entry to RD_REQ or WR_REQ and increments every cycle until DONE; counting saturates and does not wrap.
REQ-020 SHALL, when the counter reaches TIMEOUT before finish: deassert all mem requests, pulse the granted port's err (no done) for 1 cycle, leave rdata unchanged, and return to IDLE.
REQ-021 SHALL never assert read_mem_req and write_mem_req in the same cycle.
REQ-022 SHALL ignore read_mem_valid, finish and write_mem_* inputs arriving outside the matching state.
REQ-023 SHALL hold addr and out_mem_data stable for the whole access and keep them stable in IDLE.
REQ-024 SHALL allow back-to-back accesses: a request that is held high is granted in the IDLE cycle that follows DONE.

Reset
REQ-025 SHALL, with rst=1 at posedge, enter IDLE; if_done, if_err, d_done, d_err, read_mem_req and write_mem_req all =0; addr, out_mem_data, if_rdata and d_rdata =16'h0000; wait counter =0; round-robin pointer = fetch-first.
REQ-026 SHALL, when reset occurs mid-access, deassert the mem requests the next cycle and issue no done or err pulse for the aborted access.

Verification
REQ-027 SHALL cover a fetch at 16'h0040 with memory returning 16'h1234 with valid and finish 2 cycles later: read_mem_req high for 3 cycles, a one-cycle if_done pulse, and if_rdata=16'h1234.
REQ-028 SHALL cover a store of d_addr=16'h8000 and d_wdata=16'hBEEF: write_mem_req, addr=16'h8000 and out_mem_data=16'hBEEF until write_mem_valid, then d_done after finish, with read_mem_req never high.
REQ-029 SHALL cover if_req and d_req held high together for 4 accesses: grants alternate fetch, data, fetch, data, and each port gets exactly 2 done pulses.
REQ-030 SHALL cover TIMEOUT=8 with memory never responding to a load: read_mem_req drops after 8 wait cycles, d_err pulses once, d_done stays 0 and d_rdata is unchanged.
REQ-031 SHALL cover rst=1 asserted in RD_WAIT: the next cycle is IDLE with all outputs at reset values and no done pulse; a new fetch afterwards completes normally.
REQ-032 SHALL cover valid and finish asserted in the same cycle as the first read_mem_req: if_done arrives 3 cycles after if_req, with correct data.
